mips_cache_data_nway: RTL and testbench

- Parametrised N-way set-associative, write-through, no-write-allocate data cache between the MIPS CPU data port and the Avalon-style memory bus.
- Next generation of the fixed 4-way data cache. Adds configurable sets and ways, tree pseudo-LRU replacement for any power-of-two way count, and an internal miss/fill FSM that drives the memory bus directly.
- Adds defined write-miss handling and byte-enable merge on write hits.

---
 rtl/mips_cache_data_nway.sv | 182 ++++++++++++++++++
 tb/tb_mips_cache_data_nway.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_cache_data_nway.sv
// N-way set-associative write-through, no-write-allocate data cache with tree
// pseudo-LRU replacement and an internal fill/write FSM on an Avalon-style bus.
module mips_cache_data_nway #(
   parameter int INDEX_BITS = 3,
   parameter int WAY_BITS   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic        read_en,
   input  logic        write_en,
   input  logic [31:0] writedata,
   input  logic [3:0]  byte_en,
   output logic [31:0] readdata,
   output logic        stall,
   output logic [31:0] mem_address,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_writedata,
   output logic [3:0]  mem_byteenable,
   input  logic [31:0] mem_readdata,
   input  logic        mem_waitrequest
);
   localparam int SETS   = 1 << INDEX_BITS;
   localparam int WAYS   = 1 << WAY_BITS;
   localparam int TAG_W  = 30 - INDEX_BITS;
   localparam int NODE_W = WAY_BITS + 1;
   localparam int TREE_W = 2 * WAYS;

   typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

   state_t state_reg, state_next;

   logic             valid_reg [SETS][WAYS];
   logic [TAG_W-1:0] tag_reg   [SETS][WAYS];
   logic [31:0]      data_reg  [SETS][WAYS];
   logic [WAYS-2:0]  plru_reg  [SETS];

   logic [INDEX_BITS-1:0] index;
   logic [TAG_W-1:0]      tag;
   logic [WAYS-1:0]       way_hit;
   logic [WAYS-1:0]       way_inv;
   logic                  hit;
   logic [WAY_BITS-1:0]   hit_way;
   logic [WAY_BITS-1:0]   victim_way;
   logic [WAY_BITS-1:0]   touch_way;
   logic [31:0]           hit_data;
   logic [31:0]           merged_data;
   logic [TREE_W-1:0]     plru_pad;
   logic [TREE_W-1:0]     touch_tree;
   logic                  unused_ok;

   assign index     = addr[INDEX_BITS+1:2];
   assign tag       = addr[31:INDEX_BITS+2];
   assign unused_ok = &{1'b0, addr[1:0], touch_tree[TREE_W-1:WAYS-1]};

   // Tree walk from the root: a 0 bit points left, a 1 bit points right.
   function automatic logic [WAY_BITS-1:0] plru_victim(input logic [TREE_W-1:0] t);
      logic [NODE_W-1:0] node;
      node = '0;
      for (int l = 0; l < WAY_BITS; l++)
         node = {node[NODE_W-2:0], 1'b0} + NODE_W'(1) + NODE_W'(t[node]);
      return WAY_BITS'(node - NODE_W'(WAYS - 1));
   endfunction

   // Every node on the path to w is flipped to point away from w.
   function automatic logic [TREE_W-1:0] plru_touch(input logic [TREE_W-1:0] t,
                                                    input logic [WAY_BITS-1:0] w);
      logic [NODE_W-1:0] node;
      logic [TREE_W-1:0] r;
      logic              d;
      node = '0;
      r    = t;
      for (int l = 0; l < WAY_BITS; l++) begin
         d       = w[WAY_BITS-1-l];
         r[node] = ~d;
         node    = {node[NODE_W-2:0], 1'b0} + NODE_W'(1) + NODE_W'(d);
      end
      return r;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < WAYS; gi++) begin : g_way
         assign way_hit[gi] = valid_reg[index][gi] && (tag_reg[index][gi] == tag);
         assign way_inv[gi] = ~valid_reg[index][gi];
      end
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign merged_data[8*gi +: 8] = byte_en[gi] ? writedata[8*gi +: 8]
                                                     : hit_data[8*gi +: 8];
      end
   endgenerate

   assign hit      = |way_hit;
   assign hit_data = data_reg[index][hit_way];
   assign plru_pad = {{(WAYS + 1){1'b0}}, plru_reg[index]};

   always_comb begin
      hit_way = '0;
      for (int w = 0; w < WAYS; w++)
         if (way_hit[w]) hit_way = WAY_BITS'(w);
   end

   // An empty way is always filled before the PLRU tree is consulted.
   always_comb begin
      victim_way = plru_victim(plru_pad);
      for (int w = WAYS - 1; w >= 0; w--)
         if (way_inv[w]) victim_way = WAY_BITS'(w);
   end

   assign touch_way  = (state_reg == FILL) ? victim_way : hit_way;
   assign touch_tree = plru_touch(plru_pad, touch_way);

   assign stall = (state_reg != IDLE) | (read_en & ~hit & ~write_en) | (write_en & (|byte_en));

   always_comb begin
      state_next     = state_reg;
      readdata       = '0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_address    = {addr[31:2], 2'b00};
      mem_writedata  = writedata;
      mem_byteenable = 4'hF;
      case (state_reg)
         IDLE: begin
            if (write_en) begin
               if (|byte_en) state_next = WRITE;
            end else if (read_en) begin
               if (hit) readdata = hit_data;
               else     state_next = FILL;
            end
         end
         FILL: begin
            mem_read = 1'b1;
            if (!mem_waitrequest) state_next = IDLE;
         end
         WRITE: begin
            mem_write      = 1'b1;
            mem_byteenable = byte_en;
            if (!mem_waitrequest) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         for (int s = 0; s < SETS; s++) begin
            plru_reg[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               valid_reg[s][w] <= 1'b0;
               tag_reg[s][w]   <= '0;
               data_reg[s][w]  <= '0;
            end
         end
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (read_en && !write_en && hit)
                  plru_reg[index] <= touch_tree[WAYS-2:0];
            end
            FILL: begin
               if (!mem_waitrequest) begin
                  valid_reg[index][victim_way] <= 1'b1;
                  tag_reg[index][victim_way]   <= tag;
                  data_reg[index][victim_way]  <= mem_readdata;
                  plru_reg[index]              <= touch_tree[WAYS-2:0];
               end
            end
            WRITE: begin
               if (!mem_waitrequest && hit) begin
                  data_reg[index][hit_way] <= merged_data;
                  plru_reg[index]          <= touch_tree[WAYS-2:0];
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mips_cache_data_nway.sv
// Self-checking bench for mips_cache_data_nway: table of CPU transactions with a
// scoreboard queue, plus hand sequences for wait states and mid-fill reset.
module tb_mips_cache_data_nway;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic        read_en;
   logic        write_en;
   logic [31:0] writedata;
   logic [3:0]  byte_en;
   logic [31:0] readdata;
   logic        stall;
   logic [31:0] mem_address;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic [3:0]  mem_byteenable;
   logic [31:0] mem_readdata;
   logic        mem_waitrequest;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      int          exp_nr;
      int          exp_nw;
      int          exp_stall;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];

   int          checks = 0;
   int          errors = 0;
   int          n_reads = 0;
   int          n_writes = 0;
   logic [31:0] last_raddr = '0;
   logic [31:0] last_waddr = '0;
   logic [3:0]  last_wbe = '0;
   logic        both_seen = 1'b0;

   mips_cache_data_nway #(.INDEX_BITS(3), .WAY_BITS(2)) dut (
      .clk(clk), .rst(rst), .addr(addr), .read_en(read_en), .write_en(write_en),
      .writedata(writedata), .byte_en(byte_en), .readdata(readdata), .stall(stall),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
      .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memval(input logic [31:0] a);
      if (a == 32'h40) return 32'hDEADBEEF;
      return {a[15:0], ~a[15:0]};
   endfunction

   assign mem_readdata = memval(mem_address);

   always @(posedge clk) begin
      if (mem_read && mem_write) both_seen = 1'b1;
      if (mem_read && !mem_waitrequest) begin
         n_reads++;
         last_raddr = mem_address;
      end
      if (mem_write && !mem_waitrequest) begin
         n_writes++;
         last_waddr = mem_address;
         last_wbe   = mem_byteenable;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [31:0] a, input logic we, input logic [3:0] be,
                      input logic [31:0] wd, input logic [31:0] rd,
                      input int nr, input int nw, input int st);
      vec_t v;
      v.addr = a; v.we = we; v.be = be; v.wd = wd; v.exp_rd = rd;
      v.exp_nr = nr; v.exp_nw = nw; v.exp_stall = st;
      tbl.push_back(v);
   endtask

   // Drive one CPU request, hold it while stalled, and compare against the
   // scoreboard entry pushed at drive time.
   task automatic run_txn(input vec_t v);
      vec_t        e;
      int          r0, w0, stalls;
      logic        acc;
      logic [31:0] rd;
      r0 = n_reads;
      w0 = n_writes;
      exp_q.push_back(v);
      addr = v.addr; write_en = v.we; read_en = !v.we; byte_en = v.be; writedata = v.wd;
      #1;
      stalls = 0;
      while (stall && stalls < 100) begin
         acc = write_en && mem_write && !mem_waitrequest;
         stalls++;
         @(posedge clk); #1;
         if (acc) begin
            write_en = 1'b0;
            #1;
         end
      end
      rd = readdata;
      if (stalls >= 100) begin
         errors++;
         $display("FAIL timeout addr=%h: stall never released", v.addr);
      end
      @(posedge clk); #1;
      read_en  = 1'b0;
      write_en = 1'b0;
      e = exp_q.pop_front();
      $display("txn addr=%h we=%0d be=%b rd=%h stalls=%0d reads=%0d writes=%0d",
               e.addr, e.we, e.be, rd, stalls, n_reads - r0, n_writes - w0);
      chk("stall_cycles", 32'(stalls), 32'(e.exp_stall));
      chk("bus_reads", 32'(n_reads - r0), 32'(e.exp_nr));
      chk("bus_writes", 32'(n_writes - w0), 32'(e.exp_nw));
      if (!e.we) chk("readdata", rd, e.exp_rd);
      if (e.exp_nr > 0) chk("read_addr", last_raddr, {e.addr[31:2], 2'b00});
      if (e.exp_nw > 0) begin
         chk("write_addr", last_waddr, {e.addr[31:2], 2'b00});
         chk("write_be", 32'(last_wbe), 32'(e.be));
      end
   endtask

   initial begin
      vec_t v;
      int   r0;
      rst = 1'b1; addr = '0; read_en = 1'b0; write_en = 1'b0;
      writedata = '0; byte_en = '0; mem_waitrequest = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("reset_stall", 32'(stall), 32'd0);
      chk("reset_readdata", readdata, 32'd0);
      chk("reset_mem_read", 32'(mem_read), 32'd0);
      chk("reset_mem_write", 32'(mem_write), 32'd0);

      add(32'h040, 1'b0, 4'h0, 32'h0,        32'hDEADBEEF, 1, 0, 2);
      add(32'h040, 1'b0, 4'h0, 32'h0,        32'hDEADBEEF, 0, 0, 0);
      add(32'h000, 1'b0, 4'h0, 32'h0,        32'h0000FFFF, 1, 0, 2);
      add(32'h020, 1'b0, 4'h0, 32'h0,        32'h0020FFDF, 1, 0, 2);
      add(32'h040, 1'b0, 4'h0, 32'h0,        32'hDEADBEEF, 0, 0, 0);
      add(32'h060, 1'b0, 4'h0, 32'h0,        32'h0060FF9F, 1, 0, 2);
      add(32'h000, 1'b0, 4'h0, 32'h0,        32'h0000FFFF, 0, 0, 0);
      add(32'h080, 1'b0, 4'h0, 32'h0,        32'h0080FF7F, 1, 0, 2);
      add(32'h000, 1'b0, 4'h0, 32'h0,        32'h0000FFFF, 0, 0, 0);
      add(32'h020, 1'b0, 4'h0, 32'h0,        32'h0020FFDF, 1, 0, 2);
      add(32'h040, 1'b1, 4'b0101, 32'h11223344, 32'h0,     0, 1, 2);
      add(32'h040, 1'b0, 4'h0, 32'h0,        32'hDE22BE44, 0, 0, 0);
      add(32'h100, 1'b1, 4'hF, 32'hCAFEF00D, 32'h0,        0, 1, 2);
      add(32'h100, 1'b0, 4'h0, 32'h0,        32'h0100FEFF, 1, 0, 2);
      add(32'h040, 1'b1, 4'h0, 32'h55555555, 32'h0,        0, 0, 0);
      add(32'h040, 1'b0, 4'h0, 32'h0,        32'hDE22BE44, 0, 0, 0);
      for (int i = 0; i < tbl.size(); i++) run_txn(tbl[i]);

      // Wait states during a fill: strobe and address must hold.
      r0 = n_reads;
      mem_waitrequest = 1'b1;
      addr = 32'h44; read_en = 1'b1;
      #1;
      chk("ws_idle_stall", 32'(stall), 32'd1);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         chk("ws_mem_read", 32'(mem_read), 32'd1);
         chk("ws_mem_address", mem_address, 32'h44);
         chk("ws_stall", 32'(stall), 32'd1);
         @(posedge clk); #1;
      end
      mem_waitrequest = 1'b0;
      #1;
      chk("ws_mem_read_last", 32'(mem_read), 32'd1);
      @(posedge clk); #1;
      chk("ws_done_stall", 32'(stall), 32'd0);
      chk("ws_readdata", readdata, 32'h0044FFBB);
      chk("ws_reads", 32'(n_reads - r0), 32'd1);
      $display("txn waitstate addr=00000044 rd=%h reads=%0d", readdata, n_reads - r0);
      @(posedge clk); #1;
      read_en = 1'b0;

      // Reset while a fill is outstanding.
      mem_waitrequest = 1'b1;
      addr = 32'h48; read_en = 1'b1;
      #1;
      @(posedge clk); #1;
      chk("rf_mem_read_before", 32'(mem_read), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rf_mem_read_after", 32'(mem_read), 32'd0);
      chk("rf_mem_write_after", 32'(mem_write), 32'd0);
      rst = 1'b0; read_en = 1'b0; mem_waitrequest = 1'b0;
      #1;
      chk("rf_stall_idle", 32'(stall), 32'd0);
      $display("txn reset_mid_fill mem_read=%0d stall=%0d", mem_read, stall);
      @(posedge clk); #1;
      v.addr = 32'h040; v.we = 1'b0; v.be = 4'h0; v.wd = '0; v.exp_rd = 32'hDEADBEEF;
      v.exp_nr = 1; v.exp_nw = 0; v.exp_stall = 2;
      run_txn(v);

      chk("strobes_exclusive", 32'(both_seen), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
